mem_stage_lsu: RTL
==================

# mem_stage_lsu

Load/store unit for the MEM stage of the five-stage RV32I pipeline. It consumes the EX/MEM register outputs and drives a valid/grant data-memory bus. It stalls the pipeline while an access is outstanding, formats load data per funct3, and registers the MEM/WB payload. It is the consumer end of the EX/MEM interface and the producer of the MEM/WB interface.

## Interface
- `ADDR_W`, default 32: data bus address width.
- `i_clk`  in  1  rising-edge clock
- `i_reset_n`  in  1  asynchronous active-low reset
- `MEM_i_pc`, `MEM_i_inst`  in  32 each  pass-through to WB
- `MEM_i_alu_data`  in  32  effective address for loads and stores; ALU result otherwise
- `MEM_i_rs2_data`  in  32  store data
- `MEM_i_mem_wren`  in  1  store
- `MEM_i_reg_wren`  in  1  register write enable
- `MEM_i_wb_sel`  in  2  write-back select; `WB_SEL_LD` (2'd2) marks a load
- `MEM_i_funct_3`  in  3  access size and sign
- `o_dmem_req`, `o_dmem_we`  out  1 each  request valid, write
- `o_dmem_addr`  out  ADDR_W  word-aligned address, `[1:0]`=0
- `o_dmem_wdata`  out  32  lane-shifted store data
- `o_dmem_be`  out  4  byte enables
- `i_dmem_gnt`  in  1  request accepted this cycle
- `i_dmem_rvalid`  in  1  read data valid
- `i_dmem_rdata`  in  32  read word
- `o_stall`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
- `WB_o_pc`, `WB_o_inst`, `WB_o_alu_data`, `WB_o_ld_data`  out  32 each
- `WB_o_reg_wren`  out  1
- `WB_o_wb_sel`  out  2
- `WB_o_misalign`  out  1  misaligned access trapped (macro-off only, else tied 0)

## Operation
- mem_op = `MEM_i_mem_wren` or (`MEM_i_wb_sel`==`WB_SEL_LD`).
- FSM states: IDLE, REQ, RSP, REQ2, RSP2. REQ2 and RSP2 exist only with the macro.
- IDLE:
  - No mem_op: stay in IDLE.
  - mem_op: assert `o_dmem_req` combinationally. On gnt, a store completes; a load goes to RSP. Without gnt, go to REQ.
- REQ: hold req, addr, we, be and wdata stable until gnt. Then store goes to IDLE (done), load goes to RSP.
- RSP: wait for `i_dmem_rvalid`. On rvalid, a load is done and the FSM returns to IDLE. The captured word is used for formatting.
- Byte enables:
  - SB: `4'b0001<<a[1:0]`
  - SH: `4'b0011<<a[1:0]`
  - SW: `4'b1111`
  - wdata is rs2 shifted left by 8*a[1:0].
- Load format, applied to rdata>>8*a[1:0]:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Undefined funct3 yields 0.
- `o_stall` = mem_op && !done in the current cycle. Non-memory instructions never stall.
- The MEM/WB register loads when `o_stall`=0. While stalled, it loads a bubble: `WB_o_reg_wren`=0, other fields unchanged.
- rvalid while in IDLE or REQ is ignored.

## Timing
- Reset (async, immediate):
  - All `WB_o_*` outputs = 0.
  - FSM = IDLE.
  - `o_dmem_req`/`o_dmem_we`/`o_dmem_be` = 0.
- Zero-wait memory (gnt in the request cycle, rvalid next cycle):
  - Store: 0 stall cycles.
  - Load: 1 stall cycle; WB is valid 2 edges after the load enters MEM.
- Each cycle of gnt delay adds one stall cycle. Each extra rvalid delay adds one more.
- Reset mid-access: the transaction is abandoned. The memory must also be reset; no response is expected after reset.
- EX/MEM inputs are stable while `o_stall`=1, because upstream is frozen.

## Configuration
- `MISALIGN_SPLIT_EN` defined:
  - An access crossing a word boundary is split: an LW or SW with a[1:0]≠0, or an LH/SH with a[1:0]=3.
  - First word at addr, second at addr+4, via REQ2/RSP2.
  - Loads merge the bytes of both words before extension.
  - A store's be and wdata per word are derived from the 8-byte shifted lane.
  - `WB_o_misalign` is tied 0.
- Undefined:
  - No bus request is issued for a misaligned access.
  - Done is asserted immediately and `WB_o_misalign`=1.
  - `WB_o_reg_wren`=0 for that instruction.

## Structure
- Package `lsu_pkg`:
  - `WB_SEL_*` constants.
  - funct3 constants `F3_LB..F3_LHU`.
  - `lsu_state_e` enum.
- Sub-module `lsu_load_fmt`: combinational rdata shift, merge and extension. Shared by the direct and split paths.

## Test plan
- SW at 0x100, data 0xDEADBEEF, gnt in the same cycle → be=4'hF, addr=0x100, wdata=0xDEADBEEF, `o_stall` never high.
- SB at 0x103, rs2=0x12345678 → be=4'b1000, wdata=0x78000000.
- LB at 0x102, rdata=0x00800000, rvalid after 1 cycle → `WB_o_ld_data`=0xFFFFFF80, `o_stall` high exactly 1 cycle. The same access as LBU gives 0x00000080.
- LW with gnt delayed 3 cycles and rvalid delayed 2 → request fields held stable throughout, stall for 5 cycles, one WB capture, and bubbles with reg_wren=0 in between.
- Misaligned LW at 0x102, words 0x44332211 and 0x88776655:
  - Macro on: two requests, 0x100 then 0x104, result 0x66554433.
  - Macro off: no req, `WB_o_misalign`=1.
- Reset asserted in RSP → all outputs 0 immediately, FSM IDLE. The next ADD passes with no stall.

Source files
------------

// File: rtl/lsu_pkg.sv
// Constants, state encoding and WB payload type for the MEM-stage load/store unit.
// ST_REQ2/ST_RSP2 only exist when MISALIGN_SPLIT_EN is defined.
package lsu_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_PC4 = 2'd1;
    localparam logic [1:0] WB_SEL_LD  = 2'd2;
    localparam logic [1:0] WB_SEL_CSR = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RSP  = 3'd2
`ifdef MISALIGN_SPLIT_EN
        ,
        ST_REQ2 = 3'd3,
        ST_RSP2 = 3'd4
`endif
    } lsu_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu_data;
        logic [31:0] ld_data;
        logic        reg_wren;
        logic [1:0]  wb_sel;
        logic        misalign;
    } wb_payload_t;

    // Byte-lane mask before shifting; funct3[1:0] is the size for loads and stores alike.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'b10 && off != 2'b00) || (size == 2'b01 && off == 2'b11);
    endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load data formatter: aligns the byte lane from one or two words, then sign/zero extends.
module lsu_load_fmt
    import lsu_pkg::*;
(
    input  logic [31:0] i_lo_word,
    input  logic [31:0] i_hi_word,
    input  logic [1:0]  i_byte_off,
    input  logic [2:0]  i_funct_3,
    output logic [31:0] o_ld_data
);

    logic [31:0] lane;

    always_comb begin
        lane = 32'({i_hi_word, i_lo_word} >> {i_byte_off, 3'b000});
        case (i_funct_3)
            F3_LB:   o_ld_data = {{24{lane[7]}}, lane[7:0]};
            F3_LH:   o_ld_data = {{16{lane[15]}}, lane[15:0]};
            F3_LW:   o_ld_data = lane;
            F3_LBU:  o_ld_data = {24'h0, lane[7:0]};
            F3_LHU:  o_ld_data = {16'h0, lane[15:0]};
            default: o_ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: valid/grant data bus master, pipeline stall and MEM/WB register.
// MISALIGN_SPLIT_EN splits word-crossing accesses in two; otherwise they trap via WB_o_misalign.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [31:0]       MEM_i_pc,
    input  logic [31:0]       MEM_i_inst,
    input  logic [31:0]       MEM_i_alu_data,
    input  logic [31:0]       MEM_i_rs2_data,
    input  logic              MEM_i_mem_wren,
    input  logic              MEM_i_reg_wren,
    input  logic [1:0]        MEM_i_wb_sel,
    input  logic [2:0]        MEM_i_funct_3,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [31:0]       o_dmem_wdata,
    output logic [3:0]        o_dmem_be,
    input  logic              i_dmem_gnt,
    input  logic              i_dmem_rvalid,
    input  logic [31:0]       i_dmem_rdata,
    output logic              o_stall,
    output logic [31:0]       WB_o_pc,
    output logic [31:0]       WB_o_inst,
    output logic [31:0]       WB_o_alu_data,
    output logic [31:0]       WB_o_ld_data,
    output logic              WB_o_reg_wren,
    output logic [1:0]        WB_o_wb_sel,
    output logic              WB_o_misalign
);

    lsu_state_e        state_q, state_d;
    wb_payload_t       wb_q, wb_d;
    logic              is_ld, mem_op, crosses, trap;
    logic              req, second, done;
    logic [1:0]        byte_off;
    logic [7:0]        be_wide;
    logic [63:0]       wdata_wide;
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       fmt_lo, fmt_hi, ld_data;

    assign is_ld      = (MEM_i_wb_sel == WB_SEL_LD);
    assign mem_op     = MEM_i_mem_wren | is_ld;
    assign byte_off   = MEM_i_alu_data[1:0];
    assign crosses    = crosses_word(MEM_i_funct_3[1:0], byte_off);
    assign be_wide    = {4'b0000, size_mask(MEM_i_funct_3[1:0])} << byte_off;
    assign wdata_wide = {32'h0, MEM_i_rs2_data} << {byte_off, 3'b000};
    assign base_addr  = {MEM_i_alu_data[ADDR_W-1:2], 2'b00};

`ifdef MISALIGN_SPLIT_EN
    logic [31:0] word0_q, word0_d;
    assign trap   = 1'b0;
    assign fmt_lo = (state_q == ST_RSP2) ? word0_q : i_dmem_rdata;
    assign fmt_hi = i_dmem_rdata;
`else
    assign trap   = mem_op & crosses;
    assign fmt_lo = i_dmem_rdata;
    assign fmt_hi = 32'h0;
`endif

    lsu_load_fmt u_load_fmt (
        .i_lo_word  (fmt_lo),
        .i_hi_word  (fmt_hi),
        .i_byte_off (byte_off),
        .i_funct_3  (MEM_i_funct_3),
        .o_ld_data  (ld_data)
    );

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        second  = 1'b0;
        done    = 1'b0;
`ifdef MISALIGN_SPLIT_EN
        word0_d = word0_q;
`endif
        case (state_q)
            ST_IDLE, ST_REQ: begin
                if (trap) begin
                    done = 1'b1;
                end else if (mem_op || state_q == ST_REQ) begin
                    req = 1'b1;
                    if (!i_dmem_gnt) begin
                        state_d = ST_REQ;
                    end else if (is_ld) begin
                        state_d = ST_RSP;
`ifdef MISALIGN_SPLIT_EN
                    end else if (crosses) begin
                        state_d = ST_REQ2;
`endif
                    end else begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RSP: begin
                if (i_dmem_rvalid) begin
`ifdef MISALIGN_SPLIT_EN
                    if (crosses) begin
                        word0_d = i_dmem_rdata;
                        state_d = ST_REQ2;
                    end else
`endif
                    begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
`ifdef MISALIGN_SPLIT_EN
            ST_REQ2: begin
                req    = 1'b1;
                second = 1'b1;
                if (i_dmem_gnt) begin
                    if (is_ld) begin
                        state_d = ST_RSP2;
                    end else begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RSP2: begin
                if (i_dmem_rvalid) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus strobes are masked by reset so they drop the instant reset asserts.
    assign o_dmem_req   = req & i_reset_n;
    assign o_dmem_we    = req & i_reset_n & MEM_i_mem_wren;
    assign o_dmem_be    = (req & i_reset_n) ? (second ? be_wide[7:4] : be_wide[3:0]) : 4'b0000;
    assign o_dmem_addr  = second ? base_addr + ADDR_W'(4) : base_addr;
    assign o_dmem_wdata = second ? wdata_wide[63:32] : wdata_wide[31:0];
    assign o_stall      = mem_op & ~done & i_reset_n;

    always_comb begin
        wb_d          = wb_q;
        wb_d.reg_wren = 1'b0;
        if (!o_stall) begin
            wb_d.pc       = MEM_i_pc;
            wb_d.inst     = MEM_i_inst;
            wb_d.alu_data = MEM_i_alu_data;
            wb_d.ld_data  = ld_data;
            wb_d.reg_wren = MEM_i_reg_wren & ~trap;
            wb_d.wb_sel   = MEM_i_wb_sel;
            wb_d.misalign = trap;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            wb_q    <= '0;
`ifdef MISALIGN_SPLIT_EN
            word0_q <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
`ifdef MISALIGN_SPLIT_EN
            word0_q <= word0_d;
`endif
        end
    end

    assign WB_o_pc       = wb_q.pc;
    assign WB_o_inst     = wb_q.inst;
    assign WB_o_alu_data = wb_q.alu_data;
    assign WB_o_ld_data  = wb_q.ld_data;
    assign WB_o_reg_wren = wb_q.reg_wren;
    assign WB_o_wb_sel   = wb_q.wb_sel;
    assign WB_o_misalign = wb_q.misalign;

endmodule
